// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store width codes (funct3)
//   - FSM state encoding
//   - latched request record
//   - default access timeout (used when LSU_TIMEOUT_EN is defined)
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned LSU_TIMEOUT_DEF = 255;

  // Data word viewed as byte lanes.
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WB     = 2'd2,
    ERR    = 2'd3
  } lsu_state_e;

  // Fields of the accepted request still needed after IDLE.
  typedef struct packed {
    logic       load;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
    logic [4:0] rd;
  } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   addr_lo   in  2 : byte offset within the word
//   funct3    in  3 : access width code
//   wdata     in 32 : right-justified store data
//   rdata     in 32 : word read from memory
//   wstrb     out 4 : store byte enables (meaningless for loads)
//   wdata_al  out 32: store data replicated onto every candidate lane
//   load_data out 32: extracted and extended load result
//   misaligned out 1: access misaligned or funct3 not a legal width
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_al,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [NUM_LANES-1:0][LANE_W-1:0] rlanes;
  logic [LANE_W-1:0]                rbyte;
  logic [15:0]                      rhalf;

  assign rlanes = rdata;
  assign rbyte  = rlanes[addr_lo];
  assign rhalf  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Store side. BU/HU codes on a store behave as B/H; only the three
  // unused codes are rejected.
  always_comb begin
    wstrb      = 4'b0000;
    wdata_al   = wdata;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        wstrb    = 4'b0001 << addr_lo;
        wdata_al = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        misaligned = addr_lo[0];
        wstrb      = 4'b0011 << addr_lo;
        wdata_al   = {2{wdata[15:0]}};
      end
      F3_W: begin
        misaligned = |addr_lo;
        wstrb      = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{rbyte[7]}}, rbyte};
      F3_BU:   load_data = {24'h0, rbyte};
      F3_H:    load_data = {{16{rhalf[15]}}, rhalf};
      F3_HU:   load_data = {16'h0, rhalf};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and the register file.
// Takes one load/store per req_valid/req_ready handshake, runs a single
// data-bus transfer and, for loads, writes the extended result to the
// register file as a one-cycle pulse. Misaligned or illegal-width requests
// retire through ERR without any bus activity.
//
// Optional feature: define LSU_TIMEOUT_EN to abort an ACCESS after
// TIMEOUT_CYCLES cycles without mem_ready (reported on bus_err).
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_load, req_funct3,
//   req_addr, req_wdata,req_rd request fields
//   mem_valid/mem_ready        bus handshake
//   mem_addr/mem_wstrb/
//   mem_wdata/mem_rdata        bus address, byte enables, data
//   rf_we/rf_w/rf_data         register-file write port
//   done/misaligned/bus_err    retirement pulse and error flags
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_w,
  output logic [31:0] rf_data,
  output logic        done,
  output logic        misaligned,
  output logic        bus_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT_CYCLES must be in 1..65535");
  end

  lsu_state_e state, state_n;
  lsu_req_t   req_q;

  logic        accept;
  logic        xfer_done;
  logic        tmo;
  logic [1:0]  al_addr_lo;
  logic [2:0]  al_funct3;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_mis;

  // One aligner serves both phases: in IDLE it looks at the incoming
  // request (lanes, misalignment), afterwards at the latched request so
  // the returning read word can be extracted.
  assign al_addr_lo = (state == IDLE) ? req_addr[1:0] : req_q.addr_lo;
  assign al_funct3  = (state == IDLE) ? req_funct3    : req_q.funct3;

  lsu_align u_align (
    .addr_lo   (al_addr_lo),
    .funct3    (al_funct3),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .wstrb     (al_wstrb),
    .wdata_al  (al_wdata),
    .load_data (al_load),
    .misaligned(al_mis)
  );

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;

  // Counter holds the number of ACCESS cycles already spent, so the
  // TIMEOUT_CYCLES-th cycle without mem_ready is the abort cycle.
  assign tmo = (state == ACCESS) && !mem_ready && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                tmo_cnt <= '0;
    else if (accept)          tmo_cnt <= '0;
    else if (state == ACCESS) tmo_cnt <= tmo_cnt + 16'd1;
  end
`else
  assign tmo = 1'b0;
`endif

  assign xfer_done = (state == ACCESS) && mem_ready;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_n = al_mis ? ERR : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ready)  state_n = req_q.load ? WB : IDLE;
        else if (tmo)   state_n = IDLE;
      end
      WB:      state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign mem_valid = (state == ACCESS);
  assign rf_w      = req_q.rd;

  // Status pulses are registered on the transition that causes them:
  // a load's done lands in WB, a store's or timeout's in the following
  // IDLE cycle, a misaligned request's in ERR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_q      <= '0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= '0;
      rf_data    <= '0;
      rf_we      <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_n;
      done       <= xfer_done || (accept && al_mis) || tmo;
      misaligned <= accept && al_mis;
      rf_we      <= xfer_done && req_q.load && (req_q.rd != 5'd0);
      if (accept) begin
        req_q     <= '{load: req_load, funct3: req_funct3,
                       addr_lo: req_addr[1:0], rd: req_rd};
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wstrb <= (req_load || al_mis) ? 4'b0000 : al_wstrb;
        mem_wdata <= al_wdata;
      end
      if (xfer_done && req_q.load) rf_data <= al_load;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus_err <= 1'b0;
    else       bus_err <= tmo;
  end
`else
  assign bus_err = 1'b0;
`endif

endmodule
